// File: rtl/fp_to_pcm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_to_pcm_pkg
// Brief   : Shared float field constants, FSM states and field helpers.
// Revision: 1.0 - initial release
// ============================================================================
package fp_to_pcm_pkg;

  localparam int C_EXP_BIAS = 127;
  localparam int C_EXP_W    = 8;
  localparam int C_MANT_W   = 23;
  localparam int C_MAG_W    = C_MANT_W + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SHIFT  = 3'd2,
    FINISH = 3'd3,
    OUT    = 3'd4
  } state_t;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [C_EXP_W-1:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [C_MANT_W-1:0] fp_mant(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module  : fp_classify
// Brief   : Combinational IEEE-754 single class decode from exponent/mantissa.
// Revision: 1.0 - initial release
// ============================================================================
module fp_classify
  import fp_to_pcm_pkg::*;
(
  input  logic [C_EXP_W-1:0]  exp,
  input  logic [C_MANT_W-1:0] mant,
  output logic                is_zero,
  output logic                is_denorm,
  output logic                is_inf,
  output logic                is_nan
);

  logic w_exp_min;
  logic w_exp_max;
  logic w_mant_nz;

  assign w_exp_min = (exp == '0);
  assign w_exp_max = (&exp);
  assign w_mant_nz = (|mant);

  assign is_zero   = w_exp_min && !w_mant_nz;
  assign is_denorm = w_exp_min &&  w_mant_nz;
  assign is_inf    = w_exp_max && !w_mant_nz;
  assign is_nan    = w_exp_max &&  w_mant_nz;

endmodule
`default_nettype wire

// File: rtl/fp_to_pcm.sv
`default_nettype none
// ============================================================================
// Module  : fp_to_pcm
// Brief   : Iterative float32 -> signed Q1.(OUT_W-1) PCM converter with
//           round/saturate and valid/ready on both sides.
//           FP2PCM_ROUND_EN: round half away from zero (else truncate).
// Revision: 1.0 - initial release
// ============================================================================
module fp_to_pcm
  import fp_to_pcm_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  // Right-shift distance that maps the hidden-one magnitude onto the PCM LSB.
  localparam int C_RSH_BASE = C_EXP_BIAS + C_MANT_W + 1;
  localparam logic [C_MAG_W:0] C_POS_MAX = (C_MAG_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic [C_MAG_W:0] C_NEG_MAX = (C_MAG_W+1)'(64'd1 << (OUT_W-1));

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sign;
  logic [C_EXP_W-1:0]   r_exp;
  logic [C_MAG_W-1:0]   r_mag;
  logic [C_MAG_W-1:0]   w_mag_shr;
  logic [4:0]           r_rem;
  logic [2:0]           w_step;
  logic signed [9:0]    w_r;
  logic                 w_is_zero;
  logic                 w_is_denorm;
  logic                 w_is_inf;
  logic                 w_is_nan;
  logic                 w_to_zero;
  logic                 w_to_sat;
  logic [C_MAG_W:0]     w_rounded;
  logic [OUT_W-1:0]     w_pcm_mag;
  logic [OUT_W-1:0]     w_pcm;
  logic                 w_sat;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_sat;

  fp_classify u_classify (
    .exp       (r_exp),
    .mant      (r_mag[C_MANT_W-1:0]),
    .is_zero   (w_is_zero),
    .is_denorm (w_is_denorm),
    .is_inf    (w_is_inf),
    .is_nan    (w_is_nan)
  );

  assign w_r       = $signed(10'(C_RSH_BASE - OUT_W)) - $signed({2'b00, r_exp});
  assign w_to_zero = w_is_zero || w_is_denorm || w_is_nan || (w_r > 10'sd24);
  assign w_to_sat  = !w_to_zero && (w_is_inf || (w_r < 10'sd1));

  assign w_step    = (r_rem > 5'd4) ? 3'd4 : r_rem[2:0];
  assign w_mag_shr = r_mag >> w_step;

`ifdef FP2PCM_ROUND_EN
  logic r_guard;
  logic w_guard_next;

  always_comb begin
    w_guard_next = r_guard;
    case (w_step)
      3'd1:    w_guard_next = r_mag[0];
      3'd2:    w_guard_next = r_mag[1];
      3'd3:    w_guard_next = r_mag[2];
      3'd4:    w_guard_next = r_mag[3];
      default: w_guard_next = r_guard;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || r_state == DECODE) begin
      r_guard <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_guard <= w_guard_next;
    end
  end

  assign w_rounded = {1'b0, r_mag} + {{C_MAG_W{1'b0}}, r_guard};
`else
  assign w_rounded = {1'b0, r_mag};
`endif

  always_comb begin
    w_sat     = 1'b0;
    w_pcm_mag = w_rounded[OUT_W-1:0];
    w_pcm     = r_sign ? -w_pcm_mag : w_pcm_mag;
    if (!r_sign && (w_rounded > C_POS_MAX)) begin
      w_pcm = C_POS_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (r_sign && (w_rounded > C_NEG_MAX)) begin
      w_pcm = C_NEG_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = DECODE;
      DECODE:  w_state_next = (w_to_zero || w_to_sat) ? FINISH : SHIFT;
      SHIFT:   if (r_rem <= 5'd4) w_state_next = FINISH;
      FINISH:  w_state_next = OUT;
      OUT:     if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mag      <= '0;
      r_rem      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= fp_sign(in_data);
            r_exp  <= fp_exp(in_data);
            r_mag  <= {2'b01, fp_mant(in_data)};
          end
        end
        DECODE: begin
          r_rem <= w_r[4:0];
          // Forcing an oversized magnitude lets the clamp produce the sign-dependent limit.
          if (w_to_zero) begin
            r_mag <= '0;
          end else if (w_to_sat) begin
            r_mag <= '1;
          end
        end
        SHIFT: begin
          r_mag <= w_mag_shr;
          r_rem <= r_rem - {2'b00, w_step};
        end
        FINISH: begin
          r_out_data <= w_pcm;
          r_out_sat  <= w_sat;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_pcm.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_to_pcm
// Brief   : Randomized self-checking bench for fp_to_pcm against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_to_pcm;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_sat;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         sat;
    int unsigned  t;
  } exp_t;

  exp_t q[$];
  int   rdy_mode = 0;
  bit   first_seen = 1'b0;
  int   valid_age = 0;
  bit   want_ready = 1'b0;

  fp_to_pcm #(.OUT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // value = (2^23+mant) * 2^(e-150); PCM = value * 2^(W-1), rounded and clamped
  function automatic void model(input logic [31:0] f, output logic [W-1:0] d,
                                output logic s, output int lat);
    int     e;
    int     r;
    bit     neg;
    longint m;
    longint qv;
    longint v;
    longint maxp;
    longint minn;
`ifdef FP2PCM_ROUND_EN
    longint rem;
`endif
    e    = int'(f[30:23]);
    m    = longint'(f[22:0]) + (longint'(1) << 23);
    neg  = f[31];
    maxp = (longint'(1) << (W-1)) - 1;
    minn = -(longint'(1) << (W-1));
    lat  = 2;
    v    = 0;
    s    = 1'b0;
    if (e == 0 || (e == 255 && f[22:0] != 0)) begin
      v = 0;
    end else if (e == 255) begin
      s = 1'b1;
      v = neg ? minn : maxp;
    end else begin
      r = 151 - W - e;
      if (r <= 0) begin
        s = 1'b1;
        v = neg ? minn : maxp;
      end else if (r >= 25) begin
        v = 0;
      end else begin
        lat = 2 + (r + 3) / 4;
        qv  = m >> r;
`ifdef FP2PCM_ROUND_EN
        rem = m - (qv << r);
        if (2 * rem >= (longint'(1) << r)) qv++;
`endif
        v = neg ? -qv : qv;
        if (v > maxp) begin
          v = maxp; s = 1'b1;
        end else if (v < minn) begin
          v = minn; s = 1'b1;
        end
      end
    end
    d = v[W-1:0];
  endfunction

  task automatic pin(input logic [31:0] f, input logic [W-1:0] d, input logic s);
    logic [W-1:0] md;
    logic         ms;
    int           ml;
    model(f, md, ms, ml);
    chk($sformatf("model_data_%h", f), 32'(md), 32'(d));
    chk($sformatf("model_sat_%h", f), 32'(ms), 32'(s));
  endtask

  task automatic send(input logic [31:0] f);
    logic [W-1:0] ed;
    logic         es;
    int           lat;
    int           n;
    model(f, ed, es, lat);
    in_valid = 1'b1;
    in_data  = f;
    n = 0;
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", n);
        finish_run();
      end
      @(negedge clk);
    end
    q.push_back('{ed, es, cyc + 1 + int'(lat)});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0) begin
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL drain_timeout: %0d samples pending, required 0", q.size());
        finish_run();
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      first_seen = 1'b0;
      want_ready = 1'b0;
      valid_age  = 0;
      out_ready  = 1'b0;
    end else begin
      if (want_ready) begin
        chk("in_ready_after_out", 32'(in_ready), 32'd1);
        want_ready = 1'b0;
      end
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(out_valid && valid_age < 10);
        default: out_ready = 1'b1;
      endcase
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: out_valid 1 with data %h, required out_valid 0", out_data);
        end else begin
          if (!first_seen) begin
            chk("latency_cycle", cyc, q[0].t);
            first_seen = 1'b1;
          end
          chk("out_data", 32'(out_data), 32'(q[0].data));
          chk("out_sat", 32'(out_sat), 32'(q[0].sat));
          chk("in_ready_during_out", 32'(in_ready), 32'd0);
          valid_age++;
          if (out_ready) begin
            void'(q.pop_front());
            first_seen = 1'b0;
            valid_age  = 0;
            want_ready = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] md;
    logic         ms;
    int           ml;
    logic [31:0]  f;
    int           n;

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_sat", 32'(out_sat), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    pin(32'h3F000000, 16'h4000, 1'b0);
    pin(32'hBF000000, 16'hC000, 1'b0);
    pin(32'h3F800000, 16'h7FFF, 1'b1);
    pin(32'hBF800000, 16'h8000, 1'b0);
    pin(32'h47000000, 16'h7FFF, 1'b1);
    pin(32'h7FC00000, 16'h0000, 1'b0);
    pin(32'hFF800000, 16'h8000, 1'b1);
    pin(32'h80000000, 16'h0000, 1'b0);
    pin(32'h38000000, 16'h0001, 1'b0);
`ifdef FP2PCM_ROUND_EN
    pin(32'h37800000, 16'h0001, 1'b0);
`else
    pin(32'h37800000, 16'h0000, 1'b0);
`endif
    model(32'h3F000000, md, ms, ml);
    chk("model_latency_half", 32'(ml), 32'd5);

    rdy_mode = 0;
    send(32'h3F000000); send(32'hBF000000); send(32'h3F800000); send(32'hBF800000);
    send(32'h47000000); send(32'h7FC00000); send(32'hFF800000); send(32'h80000000);
    send(32'h38000000); send(32'h37800000); send(32'h00400000); send(32'h33000000);
    drain();

    rdy_mode = 2;
    send(32'h3F400000);
    send(32'hBF7FFFFF);
    drain();
    rdy_mode = 0;

    in_valid = 1'b1;
    in_data  = 32'h3F000000;
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("pre_reset_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    repeat (8) @(negedge clk);
    chk("post_reset_no_output", 32'(out_valid), 32'd0);
    send(32'hBF000000);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       f = $urandom;
        1:       f = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                      ($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'd0};
        default: f = {1'($urandom), 8'($urandom_range(105, 140)), 23'($urandom)};
      endcase
      send(f);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    finish_run();
  end

endmodule
`default_nettype wire
